matrix_link_rx: RTL and testbench

Receive end of the 8x8 RGB LED-matrix serial link. Samples the shift-register pins (SH_CP, ST_CP, DS, active-low register clear, OE) and the one-hot row select KATOT. Rebuilds the 24-bit row messages and row-by-row frames in an 8-row frame buffer. Used as an on-chip loopback/debug capture beside the display driver and as the checking model for driver regressions.

---
 rtl/matrix_pkg.sv | 34 +++
 rtl/link_edge_sync.sv | 40 ++++
 rtl/matrix_link_rx.sv | 168 ++++++++++++++++
 tb/tb_matrix_link_rx.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg
//   Shared constants and helpers for the 8x8 RGB LED-matrix link receiver.
//   MSG_W     : bits in one row message (R, G, B bytes)
//   ROWS      : rows per frame
//   *_LSB     : colour field positions inside a row message
//   row_msg_t : one row message
//   katot_to_row : one-hot row select -> {valid, row index}
package matrix_pkg;

    localparam int MSG_W   = 24;
    localparam int ROWS    = 8;
    localparam int RED_LSB = 16;
    localparam int GRN_LSB = 8;
    localparam int BLU_LSB = 0;

    typedef logic [MSG_W-1:0] row_msg_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] row;
    } row_sel_t;

    // KATOT[ROWS-1-r] selects row r, so the MSB is row 0.
    function automatic row_sel_t katot_to_row(input logic [ROWS-1:0] katot);
        row_sel_t sel;
        sel.valid = ($countones(katot) == 1);
        sel.row   = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (katot[ROWS-1-i]) sel.row = 3'(i);
        end
        return sel;
    endfunction

endpackage

// File: rtl/link_edge_sync.sv
// link_edge_sync
//   Synchronizes one asynchronous link pin into the system clock domain and
//   derives single-cycle rise/fall strobes from the synchronized level.
//   clk, rst : system clock, synchronous active-high reset
//   d        : raw asynchronous pin
//   q        : synchronized level
//   rise     : one-cycle strobe on a 0->1 transition of q
//   fall     : one-cycle strobe on a 1->0 transition of q
//   RST_VAL  : idle level of the pin; every flop loads it on reset so no
//              spurious strobe fires right after reset.
module link_edge_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
        end
    end

    assign q    = sync[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/matrix_link_rx.sv
// matrix_link_rx
//   Receive end of the 8x8 RGB LED-matrix serial link. Rebuilds 24-bit row
//   messages from the shift-register pins and stores committed rows in an
//   8-row frame buffer.
//   CLOCK, RESET        : system clock, synchronous active-high reset
//   SH_CP, ST_CP, DS    : shift clock, storage clock, serial data (async)
//   SR_CLR_N            : shift-register clear, active low (async)
//   OE                  : output enable, active low; its fall commits a row
//   KATOT[7:0]          : one-hot row select, KATOT[7-r] -> row r (async)
//   row_we/idx/msg      : one-cycle commit pulse with row index and message
//   frame_done          : one-cycle pulse when row 7 commits
//   frame_cnt           : completed frames, wraps at 16 bits
//   rd_row / rd_msg     : frame-buffer read port, 1-cycle latency
//   len_err             : sticky, a row committed with a bit count != 24
//   katot_err           : sticky, output enabled while KATOT not one-hot
module matrix_link_rx
    import matrix_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    // Fixed by the package; not meant to be overridden.
    parameter int MSG_W       = matrix_pkg::MSG_W
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             SH_CP,
    input  logic             ST_CP,
    input  logic             DS,
    input  logic             SR_CLR_N,
    input  logic             OE,
    input  logic [ROWS-1:0]  KATOT,
    output logic             row_we,
    output logic [2:0]       row_idx,
    output logic [MSG_W-1:0] row_msg,
    output logic             frame_done,
    output logic [15:0]      frame_cnt,
    input  logic [2:0]       rd_row,
    output logic [MSG_W-1:0] rd_msg,
    output logic             len_err,
    output logic             katot_err
);

    // ------------------------------------------------------------------
    // Scalar pin synchronizers, one instance per pin.
    // ------------------------------------------------------------------
    localparam int NPIN  = 5;
    localparam int P_SH  = 0;
    localparam int P_ST  = 1;
    localparam int P_DS  = 2;
    localparam int P_CLR = 3;
    localparam int P_OE  = 4;

    // Idle levels: clear and OE are active low, so they idle high.
    localparam logic [NPIN-1:0] IDLE = 5'b11000;

    logic [NPIN-1:0] pins;
    logic [NPIN-1:0] lvl;
    logic [NPIN-1:0] rise;
    logic [NPIN-1:0] fall;

    assign pins = {OE, SR_CLR_N, DS, ST_CP, SH_CP};

    for (genvar g = 0; g < NPIN; g++) begin : g_pin
        link_edge_sync #(
            .STAGES  (SYNC_STAGES),
            .RST_VAL (IDLE[g])
        ) u_sync (
            .clk  (CLOCK),
            .rst  (RESET),
            .d    (pins[g]),
            .q    (lvl[g]),
            .rise (rise[g]),
            .fall (fall[g])
        );
    end

    // Not every pin needs every strobe; keep the leftovers visibly unused.
    logic unused_strobes;
    assign unused_strobes = &{1'b0, lvl[P_SH], lvl[P_ST], lvl[P_OE],
                              rise[P_DS], rise[P_CLR], rise[P_OE],
                              fall[P_SH], fall[P_ST], fall[P_DS], fall[P_CLR]};

    logic sh_rise, st_rise, oe_fall, ds_lvl, clr_lvl;
    assign sh_rise = rise[P_SH];
    assign st_rise = rise[P_ST];
    assign oe_fall = fall[P_OE];
    assign ds_lvl  = lvl[P_DS];
    assign clr_lvl = lvl[P_CLR];

    // ------------------------------------------------------------------
    // KATOT: level-only synchronizer of the same depth, so the synced row
    // select lines up with the OE fall strobe.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][ROWS-1:0] katot_sync;

    always_ff @(posedge CLOCK) begin
        if (RESET) katot_sync <= '0;
        else       katot_sync <= {katot_sync[SYNC_STAGES-2:0], KATOT};
    end

    row_sel_t sel;
    assign sel = katot_to_row(katot_sync[SYNC_STAGES-1]);

    // ------------------------------------------------------------------
    // Shift register, latch, commit and frame buffer.
    // ------------------------------------------------------------------
    logic [MSG_W-1:0] sr;
    logic [MSG_W-1:0] lat;
    logic [4:0]       bit_cnt;
    row_msg_t         fb [ROWS];

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sr         <= '0;
            lat        <= '0;
            bit_cnt    <= '0;
            row_we     <= 1'b0;
            row_idx    <= '0;
            row_msg    <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            rd_msg     <= '0;
            len_err    <= 1'b0;
            katot_err  <= 1'b0;
            fb         <= '{default: '0};
        end else begin
            row_we     <= 1'b0;
            frame_done <= 1'b0;

            // Non-blocking read of sr gives the pre-shift value when both
            // clocks rise together, as a real 74HC595 does.
            if (st_rise) lat <= sr;

            if (!clr_lvl) begin
                sr      <= '0;
                bit_cnt <= '0;
            end else begin
                if (sh_rise) begin
                    // First bit lands in bit 0; extras past MSG_W are dropped.
                    if (bit_cnt < 5'(MSG_W)) sr[bit_cnt] <= ds_lvl;
                    if (bit_cnt != 5'd31)    bit_cnt <= bit_cnt + 5'd1;
                end
                // Any commit attempt restarts the count (overrides the
                // increment above).
                if (oe_fall) bit_cnt <= '0;
            end

            if (oe_fall) begin
                if (sel.valid) begin
                    row_we       <= 1'b1;
                    row_idx      <= sel.row;
                    row_msg      <= lat;
                    fb[sel.row]  <= lat;
                    if (bit_cnt != 5'(MSG_W)) len_err <= 1'b1;
                    if (sel.row == 3'(ROWS-1)) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                    end
                end else begin
                    katot_err <= 1'b1;
                end
            end

            // Reads see the buffer before this cycle's write.
            rd_msg <= fb[rd_row];
        end
    end

endmodule

// File: tb/tb_matrix_link_rx.sv
// tb_matrix_link_rx
//   Drives the link pins the way the display driver does (slow, well-held
//   levels) and checks committed rows against a queue of expected rows.
module tb_matrix_link_rx;

    localparam int H = 4;   // cycles each pin level is held

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        SH_CP = 1'b0;
    logic        ST_CP = 1'b0;
    logic        DS = 1'b0;
    logic        SR_CLR_N = 1'b1;
    logic        OE = 1'b1;
    logic [7:0]  KATOT = '0;
    logic [2:0]  rd_row = '0;
    logic        row_we;
    logic [2:0]  row_idx;
    logic [23:0] row_msg;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic [23:0] rd_msg;
    logic        len_err;
    logic        katot_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  idx;
        logic [23:0] msg;
        logic        fd;
    } exp_t;

    exp_t exp_q[$];

    matrix_link_rx dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .SH_CP      (SH_CP),
        .ST_CP      (ST_CP),
        .DS         (DS),
        .SR_CLR_N   (SR_CLR_N),
        .OE         (OE),
        .KATOT      (KATOT),
        .row_we     (row_we),
        .row_idx    (row_idx),
        .row_msg    (row_msg),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .rd_row     (rd_row),
        .rd_msg     (rd_msg),
        .len_err    (len_err),
        .katot_err  (katot_err)
    );

    always #5 CLOCK = ~CLOCK;

    // Scoreboard: every commit pulse must match the oldest expected row.
    always @(negedge CLOCK) begin
        if (!RESET && row_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_row_we idx=%0d msg=%h", row_idx, row_msg);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({row_idx, row_msg, frame_done} !== {e.idx, e.msg, e.fd}) begin
                    errors++;
                    $display("FAIL row_commit got idx=%0d msg=%h fd=%b want idx=%0d msg=%h fd=%b",
                             row_idx, row_msg, frame_done, e.idx, e.msg, e.fd);
                end
            end
        end
        if (!RESET && frame_done && !row_we) begin
            checks++;
            errors++;
            $display("FAIL frame_done_without_row_we");
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        DS = b;
        cyc(H);
        SH_CP = 1'b1;
        cyc(H);
        SH_CP = 1'b0;
        ST_CP = 1'b1;
        cyc(H);
        ST_CP = 1'b0;
        cyc(H);
    endtask

    task automatic clear_sr();
        SR_CLR_N = 1'b0;
        cyc(H);
        SR_CLR_N = 1'b1;
        cyc(H);
    endtask

    task automatic commit(input logic [7:0] katot);
        KATOT = katot;
        cyc(H);
        OE = 1'b0;
        cyc(H);
        OE = 1'b1;
        cyc(H);
        KATOT = '0;
        cyc(1);
    endtask

    task automatic send_row(input logic [23:0] msg, input int nbits, input logic [7:0] katot);
        clear_sr();
        for (int i = 0; i < nbits; i++) shift_bit(msg[i]);
        commit(katot);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc(1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending_rows=%0d want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic rd(input logic [2:0] r);
        rd_row = r;
        cyc(2);
    endtask

    task automatic push(input logic [2:0] idx, input logic [23:0] msg, input logic fd);
        exp_t e;
        e.idx = idx;
        e.msg = msg;
        e.fd  = fd;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        cyc(5);
        checks++;
        if ({row_we, frame_done, len_err, katot_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {row_we, frame_done, len_err, katot_err});
        end
        checks++;
        if ({row_idx, row_msg, frame_cnt, rd_msg} !== '0) begin
            errors++;
            $display("FAIL reset_values got idx=%0d msg=%h cnt=%0d rd=%h want 0",
                     row_idx, row_msg, frame_cnt, rd_msg);
        end
        RESET = 1'b0;
        cyc(6);
        checks++;
        if (row_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_spurious got row_we=%b want 0", row_we);
        end
    endtask

    task automatic test_single_row();
        push(3'd0, 24'hFF00C3, 1'b0);
        send_row(24'hFF00C3, 24, 8'h80);
        drain("single_row");
        checks++;
        if ({len_err, katot_err} !== 2'b00) begin
            errors++;
            $display("FAIL single_row_errs got len=%b katot=%b want 0 0", len_err, katot_err);
        end
    endtask

    task automatic test_frame();
        for (int r = 0; r < 8; r++) begin
            push(3'(r), 24'h1 << r, r == 7);
            send_row(24'h1 << r, 24, 8'h80 >> r);
        end
        drain("frame");
        checks++;
        if (frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL frame_cnt got %0d want 1", frame_cnt);
        end
        rd(3'd5);
        checks++;
        if (rd_msg !== 24'h000020) begin
            errors++;
            $display("FAIL read_row5 got %h want 000020", rd_msg);
        end
        rd(3'd0);
        checks++;
        if (rd_msg !== 24'h000001) begin
            errors++;
            $display("FAIL read_row0 got %h want 000001", rd_msg);
        end
    endtask

    task automatic test_short_row();
        // Only bits 0..19 arrive; the cleared upper bits stay zero.
        push(3'd1, 24'h0ABCDE, 1'b0);
        send_row(24'h0ABCDE, 20, 8'h40);
        drain("short_row");
        checks++;
        if (len_err !== 1'b1) begin
            errors++;
            $display("FAIL len_err_set got %b want 1", len_err);
        end
        push(3'd2, 24'h123456, 1'b0);
        send_row(24'h123456, 24, 8'h20);
        drain("after_short");
        checks++;
        if (len_err !== 1'b1) begin
            errors++;
            $display("FAIL len_err_sticky got %b want 1", len_err);
        end
    endtask

    task automatic test_bad_katot();
        send_row(24'h777777, 24, 8'b00011000);
        cyc(4);
        checks++;
        if (katot_err !== 1'b1) begin
            errors++;
            $display("FAIL katot_err got %b want 1", katot_err);
        end
        checks++;
        if (frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL bad_katot_frame_cnt got %0d want 1", frame_cnt);
        end
        rd(3'd3);
        checks++;
        if (rd_msg !== 24'h000008) begin
            errors++;
            $display("FAIL bad_katot_fb got %h want 000008", rd_msg);
        end
    endtask

    task automatic test_same_edge();
        // Latch still holds 777777 here; clear sr, then both clocks together.
        clear_sr();
        DS = 1'b1;
        cyc(H);
        SH_CP = 1'b1;
        ST_CP = 1'b1;
        cyc(H);
        SH_CP = 1'b0;
        ST_CP = 1'b0;
        cyc(H);
        push(3'd4, 24'h000000, 1'b0);
        commit(8'h08);
        drain("same_edge_lat");
        // A lone storage clock now exposes sr, which got the DS bit.
        ST_CP = 1'b1;
        cyc(H);
        ST_CP = 1'b0;
        cyc(H);
        push(3'd4, 24'h000001, 1'b0);
        commit(8'h08);
        drain("same_edge_sr");
        // Shifts during clear must not advance the bit position.
        SR_CLR_N = 1'b0;
        cyc(H);
        for (int i = 0; i < 5; i++) shift_bit(1'b1);
        SR_CLR_N = 1'b1;
        cyc(H);
        for (int i = 0; i < 24; i++) shift_bit(24'h5A5A5A >> i);
        push(3'd6, 24'h5A5A5A, 1'b0);
        commit(8'h02);
        drain("clear_holds_cnt");
    endtask

    task automatic test_reset_mid_row();
        clear_sr();
        for (int i = 0; i < 12; i++) shift_bit(1'b1);
        RESET = 1'b1;
        cyc(4);
        RESET = 1'b0;
        cyc(4);
        checks++;
        if ({len_err, katot_err, frame_cnt, row_idx, row_msg} !== '0) begin
            errors++;
            $display("FAIL mid_reset got len=%b katot=%b cnt=%0d idx=%0d msg=%h want 0",
                     len_err, katot_err, frame_cnt, row_idx, row_msg);
        end
        rd(3'd3);
        checks++;
        if (rd_msg !== 24'h0) begin
            errors++;
            $display("FAIL mid_reset_fb got %h want 000000", rd_msg);
        end
        push(3'd7, 24'hC0FFEE, 1'b1);
        send_row(24'hC0FFEE, 24, 8'h01);
        drain("post_reset_row");
        checks++;
        if ({len_err, frame_cnt} !== {1'b0, 16'd1}) begin
            errors++;
            $display("FAIL post_reset got len=%b cnt=%0d want len=0 cnt=1", len_err, frame_cnt);
        end
        // Stand in for 65535 completed frames.
        force dut.frame_cnt = 16'hFFFF;
        cyc(1);
        release dut.frame_cnt;
        cyc(1);
        push(3'd7, 24'h000100, 1'b1);
        send_row(24'h000100, 24, 8'h01);
        drain("wrap_row");
        checks++;
        if (frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL frame_cnt_wrap got %0d want 0", frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_frame();
        test_short_row();
        test_bad_katot();
        test_same_edge();
        test_reset_mid_row();
        cyc(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
